// File: rtl/chain_constraint_sequencer.sv
// rtl/chain_constraint_sequencer.sv - per-step Verlet broadcast and chain constraint solver
//
// Purpose:
//   Runs one simulation step for the rope/chain node array. It first pulses
//   verlet_state to every node and allows one cycle for the node registers to
//   update. It then makes ITERATIONS passes along the chain. Each pass pins
//   node 0 to the anchor. Each later node is read through the external
//   position mux, clamped per axis to within REST of its corrected
//   predecessor, and written back through that node's fix-constraint port.
//
// Optional feature macro: FLOOR_CLAMP_EN
//   When defined, the corrected y is also floored at FLOOR_Y. The anchor is
//   never floored.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   step_start   request one step (sampled only while idle)
//   pos_x/pos_y  position of the node selected by node_sel (external mux)
//   node_sel     index of the node presented on pos_x/pos_y
//   verlet_state broadcast Verlet-update enable
//   fix_state    one-hot fix_constraint_state, bit i to node i
//   fix_x/fix_y  shared x/y fix-constraint buses
//   busy         high from step acceptance through DONE
//   done         one-cycle pulse at the end of a step
module chain_constraint_sequencer #(
    parameter int          NODES      = 8,
    parameter int          SEL_W      = 3,
    parameter int          ITERATIONS = 2,
    parameter logic [31:0] REST       = 32'h0000A000,
    parameter logic [31:0] ANCHOR_X   = 32'h000C8000,
    parameter logic [31:0] ANCHOR_Y   = 32'h00000000
`ifdef FLOOR_CLAMP_EN
    ,
    parameter logic [31:0] FLOOR_Y    = 32'hFFF38000
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_start,
    input  logic [31:0]       pos_x,
    input  logic [31:0]       pos_y,
    output logic [SEL_W-1:0]  node_sel,
    output logic              verlet_state,
    output logic [NODES-1:0]  fix_state,
    output logic [31:0]       fix_x,
    output logic [31:0]       fix_y,
    output logic              busy,
    output logic              done
);

    localparam int ITER_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic [SEL_W-1:0]  IDX_LAST  = SEL_W'(NODES - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITERATIONS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VERLET = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_PIN    = 3'd3;
    localparam logic [2:0] S_SEL    = 3'd4;
    localparam logic [2:0] S_CALC   = 3'd5;
    localparam logic [2:0] S_WRITE  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]        state_q,  state_d;
    logic [SEL_W-1:0]  idx_q,    idx_d;
    logic [ITER_W-1:0] iter_q,   iter_d;
    logic [31:0]       prev_x_q, prev_x_d;
    logic [31:0]       prev_y_q, prev_y_d;
    logic [31:0]       fix_x_q,  fix_x_d;
    logic [31:0]       fix_y_q,  fix_y_d;

    logic [31:0]       res_x;
    logic [31:0]       res_y;

    // The difference is taken at 33 bits so that it cannot wrap. The result is
    // always within REST of prev, so truncating it back to 32 bits is exact.
    function automatic logic [31:0] clamp_axis(input logic [31:0] cur,
                                               input logic [31:0] prev);
        logic signed [32:0] diff;
        logic signed [32:0] lim;
        diff = $signed({cur[31], cur}) - $signed({prev[31], prev});
        lim  = $signed({1'b0, REST});
        if (diff > lim) begin
            clamp_axis = prev + REST;
        end else if (diff < -lim) begin
            clamp_axis = prev - REST;
        end else begin
            clamp_axis = cur;
        end
    endfunction

    // pos_x/pos_y have been stable since SEL, so they are used directly in CALC.
    always_comb begin
        res_x = clamp_axis(pos_x, prev_x_q);
        res_y = clamp_axis(pos_y, prev_y_q);
`ifdef FLOOR_CLAMP_EN
        if ($signed(res_y) < $signed(FLOOR_Y)) begin
            res_y = FLOOR_Y;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        iter_d   = iter_q;
        prev_x_d = prev_x_q;
        prev_y_d = prev_y_q;
        fix_x_d  = fix_x_q;
        fix_y_d  = fix_y_q;
        case (state_q)
            S_IDLE: begin
                if (step_start) begin
                    state_d = S_VERLET;
                end
            end
            S_VERLET: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // The anchor must already be on the bus during PIN.
                state_d = S_PIN;
                fix_x_d = ANCHOR_X;
                fix_y_d = ANCHOR_Y;
            end
            S_PIN: begin
                prev_x_d = ANCHOR_X;
                prev_y_d = ANCHOR_Y;
                idx_d    = SEL_W'(1);
                state_d  = S_SEL;
            end
            S_SEL: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                fix_x_d = res_x;
                fix_y_d = res_y;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                prev_x_d = fix_x_q;
                prev_y_d = fix_y_q;
                if (idx_q != IDX_LAST) begin
                    idx_d   = idx_q + SEL_W'(1);
                    state_d = S_SEL;
                end else if (iter_q != ITER_LAST) begin
                    iter_d  = iter_q + ITER_W'(1);
                    fix_x_d = ANCHOR_X;
                    fix_y_d = ANCHOR_Y;
                    state_d = S_PIN;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                iter_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            iter_q   <= '0;
            prev_x_q <= '0;
            prev_y_q <= '0;
            fix_x_q  <= '0;
            fix_y_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            iter_q   <= iter_d;
            prev_x_q <= prev_x_d;
            prev_y_q <= prev_y_d;
            fix_x_q  <= fix_x_d;
            fix_y_q  <= fix_y_d;
        end
    end

    // All outputs decode directly from registers, so an asynchronous reset
    // clears them in the same cycle.
    always_comb begin
        fix_state = '0;
        for (int i = 0; i < NODES; i++) begin
            fix_state[i] = ((state_q == S_WRITE) && (idx_q == SEL_W'(i))) ||
                           ((state_q == S_PIN) && (i == 0));
        end
    end

    assign node_sel     = ((state_q == S_SEL) || (state_q == S_CALC)) ? idx_q : '0;
    assign verlet_state = (state_q == S_VERLET);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign fix_x        = fix_x_q;
    assign fix_y        = fix_y_q;

endmodule

// File: tb/tb_chain_constraint_sequencer.sv
// tb/tb_chain_constraint_sequencer.sv - self-checking bench for chain_constraint_sequencer
module tb_chain_constraint_sequencer;

    localparam int          NODES  = 8;
    localparam int          SEL_W  = 3;
    localparam int          ITERS  = 2;
    localparam logic [31:0] TREST  = 32'h0000A000;
    localparam logic [31:0] AX     = 32'h000C8000;
    localparam logic [31:0] AY     = 32'h00000000;
    localparam logic [31:0] FLOORY = 32'hFFF38000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              step_start = 1'b0;
    logic [31:0]       pos_x, pos_y;
    logic [SEL_W-1:0]  node_sel;
    logic              verlet_state;
    logic [NODES-1:0]  fix_state;
    logic [31:0]       fix_x, fix_y;
    logic              busy, done;

    logic              step2 = 1'b0;
    logic [31:0]       pos2_x, pos2_y;
    logic [SEL_W-1:0]  sel2;
    logic              verlet2;
    logic [NODES-1:0]  fix2;
    logic [31:0]       fix2_x, fix2_y;
    logic              busy2, done2;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        int          idx;
        logic [31:0] x;
        logic [31:0] y;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] node_x [NODES];
    logic [31:0] node_y [NODES];
    logic [31:0] init_x [NODES];
    logic [31:0] init_y [NODES];
    logic [31:0] m_x [NODES];
    logic [31:0] m_y [NODES];
    logic        load_nodes = 1'b0;
    int          wr_cnt = 0;

    int vcnt, vlast, dcnt, dlast;

    always #5 clk = ~clk;

    chain_constraint_sequencer dut (
        .clk(clk), .reset(reset), .step_start(step_start),
        .pos_x(pos_x), .pos_y(pos_y), .node_sel(node_sel),
        .verlet_state(verlet_state), .fix_state(fix_state),
        .fix_x(fix_x), .fix_y(fix_y), .busy(busy), .done(done)
    );

    chain_constraint_sequencer #(.REST(32'h7FFFFFFF)) dut_wide (
        .clk(clk), .reset(reset), .step_start(step2),
        .pos_x(pos2_x), .pos_y(pos2_y), .node_sel(sel2),
        .verlet_state(verlet2), .fix_state(fix2),
        .fix_x(fix2_x), .fix_y(fix2_y), .busy(busy2), .done(done2)
    );

    assign pos_x  = node_x[node_sel];
    assign pos_y  = node_y[node_sel];
    assign pos2_x = 32'h0;
    assign pos2_y = (sel2 == 3'd4) ? 32'hFFED4000 : 32'h0;

    // Behavioural node registers: take the fix-constraint value when selected.
    always @(posedge clk) begin
        if (load_nodes) begin
            for (int i = 0; i < NODES; i++) begin
                node_x[i] <= init_x[i];
                node_y[i] <= init_y[i];
            end
        end else if (reset) begin
            for (int i = 0; i < NODES; i++) begin
                if (fix_state[i]) begin
                    node_x[i] <= fix_x;
                    node_y[i] <= fix_y;
                end
            end
        end
    end

    // Scoreboard: every fix write is popped and compared.
    always @(negedge clk) begin
        if (reset && (fix_state != '0 || verlet_state)) begin
            tests_run++;
            if (!$onehot0(fix_state) || (verlet_state && fix_state != '0)) begin
                tests_failed++;
                $display("FAIL strobe_exclusive fix_state=%b verlet=%b required onehot0 and exclusive",
                         fix_state, verlet_state);
            end
            if (fix_state != '0) begin
                int got;
                exp_t e;
                got = -1;
                for (int i = 0; i < NODES; i++) if (fix_state[i]) got = i;
                wr_cnt++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_underflow write idx=%0d x=%h y=%h with nothing expected", got, fix_x, fix_y);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e.idx || fix_x !== e.x || fix_y !== e.y) begin
                        tests_failed++;
                        $display("FAIL sb_write got idx=%0d x=%h y=%h required idx=%0d x=%h y=%h",
                                 got, fix_x, fix_y, e.idx, e.x, e.y);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] ref_clamp(input logic [31:0] cur, input logic [31:0] prev);
        longint d;
        d = longint'($signed(cur)) - longint'($signed(prev));
        if (d > longint'(TREST)) return prev + TREST;
        if (d < -longint'(TREST)) return prev - TREST;
        return cur;
    endfunction

    task automatic set_default_nodes();
        for (int k = 0; k < NODES; k++) begin
            init_x[k] = AX;
            init_y[k] = -(k * TREST);
        end
    endtask

    task automatic load_nodes_now();
        for (int k = 0; k < NODES; k++) begin
            m_x[k] = init_x[k];
            m_y[k] = init_y[k];
        end
        @(negedge clk) load_nodes = 1'b1;
        @(negedge clk) load_nodes = 1'b0;
    endtask

    task automatic build_expected();
        logic [31:0] px, py;
        for (int it = 0; it < ITERS; it++) begin
            exp_q.push_back('{idx: 0, x: AX, y: AY});
            px = AX;
            py = AY;
            for (int k = 1; k < NODES; k++) begin
                m_x[k] = ref_clamp(m_x[k], px);
                m_y[k] = ref_clamp(m_y[k], py);
`ifdef FLOOR_CLAMP_EN
                if ($signed(m_y[k]) < $signed(FLOORY)) m_y[k] = FLOORY;
`endif
                exp_q.push_back('{idx: k, x: m_x[k], y: m_y[k]});
                px = m_x[k];
                py = m_y[k];
            end
        end
    endtask

    // Cycle c is the c-th cycle after the edge that sampled step_start.
    task automatic run_step(input int pulse_cyc, input int hold_until, input int ncyc);
        vcnt = 0; vlast = -1; dcnt = 0; dlast = -1; wr_cnt = 0;
        @(negedge clk) step_start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            if (verlet_state) begin vcnt++; vlast = c; end
            if (done) begin dcnt++; dlast = c; end
            step_start = (c == pulse_cyc) || (c < hold_until);
            @(negedge clk);
        end
        step_start = 1'b0;
    endtask

    task automatic check_int(input string name, input int got, input int req);
        tests_run++;
        if (got !== req) begin
            tests_failed++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] req);
        tests_run++;
        if (got !== req) begin
            tests_failed++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_word("rst_outputs", {busy, done, verlet_state, 29'd0},
                   32'd0);
        check_word("rst_fix_state", 32'(fix_state), 32'd0);
        check_word("rst_fix_x", fix_x, 32'd0);
        check_word("rst_fix_y", fix_y, 32'd0);
        check_word("rst_node_sel", 32'(node_sel), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_int("rst_release_busy", int'(busy), 0);
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        set_default_nodes();
        load_nodes_now();
        build_expected();
        seen = 1'b0;
        @(negedge clk) step_start = 1'b1;
        @(negedge clk) step_start = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (fix_state[3]) seen = 1'b1;
            else @(negedge clk);
        end
        check_int("midwrite_reached", int'(seen), 1);
        reset = 1'b0;
        #1;
        check_word("midwrite_fix_state", 32'(fix_state), 32'd0);
        check_word("midwrite_flags", 32'({busy, done, verlet_state}), 32'd0);
        check_word("midwrite_fix_x", fix_x, 32'd0);
        check_word("midwrite_fix_y", fix_y, 32'd0);
        check_word("midwrite_node_sel", 32'(node_sel), 32'd0);
        exp_q.delete();
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check_int("midwrite_busy_after", int'(busy), 0);
    endtask

    task automatic test_nominal();
        set_default_nodes();
        load_nodes_now();
        build_expected();
        run_step(0, 0, 60);
        check_int("nom_verlet_count", vcnt, 1);
        check_int("nom_verlet_cycle", vlast, 1);
        check_int("nom_done_count", dcnt, 1);
        check_int("nom_done_cycle", dlast, 47);
        check_int("nom_writes", wr_cnt, 2 * NODES);
        check_int("nom_sb_empty", exp_q.size(), 0);
        for (int k = 0; k < NODES; k++) begin
            check_word("nom_node_y", node_y[k], -(k * TREST));
        end
    endtask

    task automatic test_x_clamp();
        set_default_nodes();
        init_x[2] = 32'h000D7000;
        init_x[3] = 32'h000D7000;
        load_nodes_now();
        build_expected();
        run_step(0, 0, 60);
        check_word("xclamp_node2", node_x[2], 32'h000D2000);
        check_word("xclamp_node3", node_x[3], 32'h000D7000);
        check_int("xclamp_sb_empty", exp_q.size(), 0);
    endtask

    task automatic test_y_clamp();
        set_default_nodes();
        init_y[1] = 32'hFFFE7000;
        load_nodes_now();
        build_expected();
        run_step(0, 0, 60);
        check_word("yclamp_node1", node_y[1], 32'hFFFF6000);
        check_word("yclamp_node2", node_y[2], 32'hFFFEC000);
        check_int("yclamp_sb_empty", exp_q.size(), 0);
    endtask

    task automatic test_busy_ignore();
        set_default_nodes();
        load_nodes_now();
        build_expected();
        run_step(5, 0, 70);
        check_int("ignore_verlet_count", vcnt, 1);
        check_int("ignore_done_count", dcnt, 1);
        check_int("ignore_done_cycle", dlast, 47);
        check_int("ignore_sb_empty", exp_q.size(), 0);
        check_int("ignore_idle_busy", int'(busy), 0);
    endtask

    task automatic test_back_to_back();
        set_default_nodes();
        init_x[5] = 32'h000B0000;
        load_nodes_now();
        build_expected();
        build_expected();
        run_step(0, 49, 110);
        check_int("b2b_verlet_count", vcnt, 2);
        check_int("b2b_verlet_second", vlast, 49);
        check_int("b2b_done_count", dcnt, 2);
        check_int("b2b_done_second", dlast, 95);
        check_int("b2b_writes", wr_cnt, 4 * NODES);
        check_int("b2b_sb_empty", exp_q.size(), 0);
    endtask

    task automatic test_floor();
        logic [31:0] req;
        int seen4, seen_done;
`ifdef FLOOR_CLAMP_EN
        req = 32'hFFF38000;
`else
        req = 32'hFFED4000;
`endif
        seen4 = 0;
        seen_done = 0;
        @(negedge clk) step2 = 1'b1;
        @(negedge clk) step2 = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (fix2[4]) begin
                seen4++;
                check_word("floor_fix_y", fix2_y, req);
            end
            if (done2) seen_done++;
            @(negedge clk);
        end
        check_int("floor_writes_node4", seen4, 2);
        check_int("floor_done", seen_done, 1);
    endtask

    initial begin
        set_default_nodes();
        for (int k = 0; k < NODES; k++) begin
            node_x[k] = init_x[k];
            node_y[k] = init_y[k];
        end
        test_reset();
        test_reset_mid_write();
        test_nominal();
        test_x_clamp();
        test_y_clamp();
        test_busy_ignore();
        test_back_to_back();
        test_floor();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
